// File: rtl/vga_pkg.sv
// Shared VGA constants: active area, blanking marker, box direction states, palette.
package vga_pkg;
    localparam int          H_ACTIVE  = 640;
    localparam int          V_ACTIVE  = 480;
    localparam logic [9:0]  PXL_BLANK = 10'h3FF;

    typedef enum logic [1:0] {
        DIR_NE = 2'd0,
        DIR_NW = 2'd1,
        DIR_SE = 2'd2,
        DIR_SW = 2'd3
    } dir_t;

    // Channel masks {r,g,b}; each set bit becomes a full-scale channel.
    localparam logic [2:0] PAL_RED    = 3'b100;
    localparam logic [2:0] PAL_GREEN  = 3'b010;
    localparam logic [2:0] PAL_BLUE   = 3'b001;
    localparam logic [2:0] PAL_YELLOW = 3'b110;

    function automatic logic [2:0] palette_mask(input logic [1:0] idx);
        case (idx)
            2'd0:    return PAL_RED;
            2'd1:    return PAL_GREEN;
            2'd2:    return PAL_BLUE;
            default: return PAL_YELLOW;
        endcase
    endfunction

    function automatic dir_t make_dir(input logic east, input logic south);
        case ({south, east})
            2'b00:   return DIR_NW;
            2'b01:   return DIR_NE;
            2'b10:   return DIR_SW;
            default: return DIR_SE;
        endcase
    endfunction
endpackage

// File: rtl/vga_box_motion.sv
// Once-per-frame box motion: vsync falling-edge tick, bounce direction FSM, position, frame counter.
// state  | meaning
// DIR_NE | moving +x, -y
// DIR_NW | moving -x, -y
// DIR_SE | moving +x, +y
// DIR_SW | moving -x, +y
module vga_box_motion
    import vga_pkg::*;
#(
    parameter int BOX_W = 64,
    parameter int BOX_H = 48,
    parameter int STEP  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_ce,
    input  logic       run,
    input  logic       vsync,
    output logic [9:0] box_x,
    output logic [9:0] box_y,
    output logic [7:0] frame_cnt
);
    logic       vsync_q;
    logic       tick;
    dir_t       dir, dir_nxt;
    logic [9:0] box_x_nxt, box_y_nxt;
    logic       east, south, east_nxt, south_nxt;

    assign tick = pix_ce & vsync_q & ~vsync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vsync_q   <= 1'b0;
            frame_cnt <= '0;
            dir       <= DIR_SE;
            box_x     <= '0;
            box_y     <= '0;
        end else if (pix_ce) begin
            vsync_q <= vsync;
            if (tick) begin
                frame_cnt <= frame_cnt + 8'd1;
                if (run) begin
                    dir   <= dir_nxt;
                    box_x <= box_x_nxt;
                    box_y <= box_y_nxt;
                end
            end
        end
    end

    // 11-bit far-edge sums so the overflow compare cannot wrap.
    always_comb begin
        east      = (dir == DIR_NE) || (dir == DIR_SE);
        south     = (dir == DIR_SE) || (dir == DIR_SW);
        east_nxt  = east;
        south_nxt = south;
        box_x_nxt = box_x;
        box_y_nxt = box_y;

        if (east) begin
            if ({1'b0, box_x} + 11'(STEP) + 11'(BOX_W) > 11'(H_ACTIVE)) begin
                box_x_nxt = 10'(H_ACTIVE - BOX_W);
                east_nxt  = 1'b0;
            end else begin
                box_x_nxt = box_x + 10'(STEP);
            end
        end else if (box_x < 10'(STEP)) begin
            box_x_nxt = '0;
            east_nxt  = 1'b1;
        end else begin
            box_x_nxt = box_x - 10'(STEP);
        end

        if (south) begin
            if ({1'b0, box_y} + 11'(STEP) + 11'(BOX_H) > 11'(V_ACTIVE)) begin
                box_y_nxt = 10'(V_ACTIVE - BOX_H);
                south_nxt = 1'b0;
            end else begin
                box_y_nxt = box_y + 10'(STEP);
            end
        end else if (box_y < 10'(STEP)) begin
            box_y_nxt = '0;
            south_nxt = 1'b1;
        end else begin
            box_y_nxt = box_y - 10'(STEP);
        end

        dir_nxt = make_dir(east_nxt, south_nxt);
    end
endmodule

// File: rtl/vga_box_render.sv
// Bouncing bordered box renderer: 2-strobe pixel pipeline with colour mux and delayed syncs.
module vga_box_render
    import vga_pkg::*;
#(
    parameter int CW     = 4,
    parameter int BOX_W  = 64,
    parameter int BOX_H  = 48,
    parameter int STEP   = 2,
    parameter int BORDER = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_ce,
    input  logic          run,
    input  logic [9:0]    x_pxl,
    input  logic [9:0]    y_pxl,
    input  logic          href,
    input  logic          vsync,
    output logic [CW-1:0] r,
    output logic [CW-1:0] g,
    output logic [CW-1:0] b,
    output logic          href_o,
    output logic          vsync_o,
    output logic [7:0]    frame_cnt
);
    logic [9:0]    box_x, box_y;
    logic [10:0]   x11, y11, bx11, by11;
    logic          vis, in_box, in_border;
    logic          s1_vis, s1_in_box, s1_in_border, s1_href, s1_vsync;
    logic [2:0]    pal;
    logic [CW-1:0] r_nxt, g_nxt, b_nxt;

    vga_box_motion #(.BOX_W(BOX_W), .BOX_H(BOX_H), .STEP(STEP)) u_motion (
        .clk       (clk),
        .rst       (rst),
        .pix_ce    (pix_ce),
        .run       (run),
        .vsync     (vsync),
        .box_x     (box_x),
        .box_y     (box_y),
        .frame_cnt (frame_cnt)
    );

    assign x11  = {1'b0, x_pxl};
    assign y11  = {1'b0, y_pxl};
    assign bx11 = {1'b0, box_x};
    assign by11 = {1'b0, box_y};

    assign vis       = (x_pxl != PXL_BLANK) && (y_pxl != PXL_BLANK);
    assign in_box    = (x11 >= bx11) && (x11 < bx11 + 11'(BOX_W)) &&
                       (y11 >= by11) && (y11 < by11 + 11'(BOX_H));
    assign in_border = in_box &&
                       ((x11 <  bx11 + 11'(BORDER)) || (x11 >= bx11 + 11'(BOX_W - BORDER)) ||
                        (y11 <  by11 + 11'(BORDER)) || (y11 >= by11 + 11'(BOX_H - BORDER)));

    always_comb begin
        pal   = palette_mask(frame_cnt[7:6]);
        r_nxt = '0;
        g_nxt = '0;
        b_nxt = {1'b0, {(CW-1){1'b1}}};
        if (!s1_vis) begin
            b_nxt = '0;
        end else if (s1_in_border) begin
            r_nxt = '1;
            g_nxt = '1;
            b_nxt = '1;
        end else if (s1_in_box) begin
            r_nxt = {CW{pal[2]}};
            g_nxt = {CW{pal[1]}};
            b_nxt = {CW{pal[0]}};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vis       <= 1'b0;
            s1_in_box    <= 1'b0;
            s1_in_border <= 1'b0;
            s1_href      <= 1'b0;
            s1_vsync     <= 1'b0;
            r            <= '0;
            g            <= '0;
            b            <= '0;
            href_o       <= 1'b0;
            vsync_o      <= 1'b0;
        end else if (pix_ce) begin
            s1_vis       <= vis;
            s1_in_box    <= in_box;
            s1_in_border <= in_border;
            s1_href      <= href;
            s1_vsync     <= vsync;
            r            <= r_nxt;
            g            <= g_nxt;
            b            <= b_nxt;
            href_o       <= s1_href;
            vsync_o      <= s1_vsync;
        end
    end
endmodule

// File: tb/tb_vga_box_render.sv
// Directed bench for vga_box_render: colour mux, sync delay, bounce motion, run gating, async reset.
module tb_vga_box_render;
    import vga_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pix_ce = 1'b0;
    logic       run = 1'b1;
    logic [9:0] x_pxl = 10'h3FF;
    logic [9:0] y_pxl = 10'h3FF;
    logic       href = 1'b1;
    logic       vsync = 1'b1;
    logic [3:0] r, g, b;
    logic       href_o, vsync_o;
    logic [7:0] frame_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    vga_box_render dut (
        .clk       (clk),
        .rst       (rst),
        .pix_ce    (pix_ce),
        .run       (run),
        .x_pxl     (x_pxl),
        .y_pxl     (y_pxl),
        .href      (href),
        .vsync     (vsync),
        .r         (r),
        .g         (g),
        .b         (b),
        .href_o    (href_o),
        .vsync_o   (vsync_o),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One pixel strobe: inputs applied at negedge, captured at next posedge.
    task automatic px(input logic [9:0] x, input logic [9:0] y, input logic h, input logic v);
        @(negedge clk);
        x_pxl = x; y_pxl = y; href = h; vsync = v; pix_ce = 1'b1;
        @(negedge clk);
        pix_ce = 1'b0;
    endtask

    task automatic check_rgb(input string tag, input logic [9:0] x, input logic [9:0] y,
                             input logic [11:0] exp_rgb);
        px(x, y, 1'b1, 1'b1);
        px(10'h3FF, 10'h3FF, 1'b1, 1'b1);
        check_val(tag, {r, g, b}, exp_rgb);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            px(10'h3FF, 10'h3FF, 1'b1, 1'b1);
            px(10'h3FF, 10'h3FF, 1'b1, 1'b0);
        end
        px(10'h3FF, 10'h3FF, 1'b1, 1'b1);
    endtask

    task automatic check_pos(input string tag, input int ex, input int ey, input dir_t ed);
        check_val({tag, "_x"},   dut.u_motion.box_x, ex);
        check_val({tag, "_y"},   dut.u_motion.box_y, ey);
        check_val({tag, "_dir"}, dut.u_motion.dir,   ed);
    endtask

    initial begin
        #12;
        check_val("rst_rgb",   {r, g, b}, 12'h000);
        check_val("rst_href",  href_o, 1'b0);
        check_val("rst_vsync", vsync_o, 1'b0);
        check_val("rst_fcnt",  frame_cnt, 8'd0);
        @(negedge clk);
        rst = 1'b1;

        check_rgb("bg_100",     10'd100,  10'd100, 12'h007);
        check_rgb("blank_x",    10'h3FF,  10'd100, 12'h000);
        check_rgb("blank_y",    10'd5,    10'h3FF, 12'h000);
        check_rgb("border_1_1", 10'd1,    10'd1,   12'hFFF);
        check_rgb("fill_10",    10'd10,   10'd10,  12'hF00);
        check_rgb("fill_edge2", 10'd2,    10'd10,  12'hF00);
        check_rgb("border_63",  10'd63,   10'd10,  12'hFFF);
        check_rgb("right_64",   10'd64,   10'd10,  12'h007);
        check_rgb("bottom_47",  10'd10,   10'd47,  12'hFFF);
        check_rgb("below_48",   10'd10,   10'd48,  12'h007);

        // Hold: pix_ce low must freeze outputs.
        @(negedge clk);
        x_pxl = 10'd10; y_pxl = 10'd10; href = 1'b0; vsync = 1'b0;
        repeat (4) @(negedge clk);
        check_val("hold_rgb",  {r, g, b}, 12'h007);
        check_val("hold_href", href_o, 1'b1);
        check_val("hold_fcnt", frame_cnt, 8'd0);

        // Sync latency: exactly two strobes.
        px(10'h3FF, 10'h3FF, 1'b0, 1'b1);
        check_val("href_lat1", href_o, 1'b1);
        px(10'h3FF, 10'h3FF, 1'b1, 1'b1);
        check_val("href_lat2", href_o, 1'b0);
        px(10'h3FF, 10'h3FF, 1'b1, 1'b1);
        check_val("href_lat3", href_o, 1'b1);

        // Motion.
        ticks(10);
        check_pos("t10", 20, 20, DIR_SE);
        check_val("t10_fcnt", frame_cnt, 8'd10);
        check_rgb("t10_corner", 10'd20, 10'd20, 12'hFFF);
        check_rgb("t10_left",   10'd19, 10'd20, 12'h007);
        ticks(206);
        check_pos("t216", 432, 432, DIR_SE);
        ticks(1);
        check_pos("t217", 434, 432, DIR_NE);
        ticks(71);
        check_pos("t288", 576, 290, DIR_NE);
        ticks(1);
        check_pos("t289", 576, 288, DIR_NW);
        check_val("t289_fcnt", frame_cnt, 8'd33);

        // Frozen motion, frame counter keeps counting; palette switches at 64.
        run = 1'b0;
        ticks(3);
        check_pos("frz3", 576, 288, DIR_NW);
        check_val("frz3_fcnt", frame_cnt, 8'd36);
        ticks(27);
        check_val("f63", frame_cnt, 8'd63);
        check_rgb("f63_red", 10'd586, 10'd298, 12'hF00);
        ticks(1);
        check_val("f64", frame_cnt, 8'd64);
        check_rgb("f64_green", 10'd586, 10'd298, 12'h0F0);
        check_pos("frz31", 576, 288, DIR_NW);

        // Async reset mid-line with href low in flight.
        px(10'd586, 10'd298, 1'b0, 1'b1);
        px(10'd587, 10'd298, 1'b0, 1'b1);
        check_val("pre_rst_g", g, 4'hF);
        #2 rst = 1'b0;
        #1;
        check_val("arst_rgb",   {r, g, b}, 12'h000);
        check_val("arst_href",  href_o, 1'b0);
        check_val("arst_vsync", vsync_o, 1'b0);
        check_val("arst_fcnt",  frame_cnt, 8'd0);
        check_val("arst_x",     dut.u_motion.box_x, 10'd0);
        @(negedge clk);
        rst = 1'b1;
        px(10'h3FF, 10'h3FF, 1'b1, 1'b1);
        check_val("refill1_href",  href_o, 1'b0);
        check_val("refill1_vsync", vsync_o, 1'b0);
        px(10'h3FF, 10'h3FF, 1'b0, 1'b0);
        check_val("refill2_href",  href_o, 1'b1);
        check_val("refill2_vsync", vsync_o, 1'b1);
        check_val("refill_fcnt",   frame_cnt, 8'd1);
        px(10'h3FF, 10'h3FF, 1'b1, 1'b1);
        check_val("refill3_href",  href_o, 1'b0);
        check_val("refill3_vsync", vsync_o, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
